// File: rtl/hazard_pkg.sv
// Shared encodings, scoreboard entry layout and source-match helper for hazard_ctrl.
package hazard_pkg;

    // Entry address storage width; register addresses up to this width are zero-extended.
    localparam int unsigned SB_AW  = 8;
    localparam int unsigned FCNT_W = 3;

    localparam logic [1:0] FWD_RF  = 2'd0;
    localparam logic [1:0] FWD_EX  = 2'd1;
    localparam logic [1:0] FWD_ACC = 2'd2;

    localparam logic [0:0] ST_RUN   = 1'b0;
    localparam logic [0:0] ST_FLUSH = 1'b1;

    typedef struct packed {
        logic             valid;
        logic [SB_AW-1:0] wr;
        logic             load;
    } sb_entry_t;

    // A source hits an entry only if it is really read, nonzero, and the entry is a live write to it.
    function automatic logic src_match(input sb_entry_t e, input logic used,
                                       input logic [SB_AW-1:0] addr);
        return used && (addr != '0) && e.valid && (e.wr == addr);
    endfunction

endpackage

// File: rtl/hazard_scoreboard.sv
// Two-entry in-flight write tracker (EX, accumulator) with per-source forwarding selects.
module hazard_scoreboard
    import hazard_pkg::*;
#(
    parameter int unsigned REG_AW = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ins_i,
    input  logic [REG_AW-1:0] ins_wr_i,
    input  logic              ins_load_i,
    input  logic [REG_AW-1:0] rs_i,
    input  logic              rs_used_i,
    input  logic [REG_AW-1:0] rt_i,
    input  logic              rt_used_i,
    output logic [1:0]        fwd_rs_c_o,
    output logic [1:0]        fwd_rt_c_o,
    output logic              load_hit_c_o
);

    sb_entry_t e0_q, e0_d, e1_q;
    logic      rs_m0, rs_m1, rt_m0, rt_m1;

    // Next EX entry: the decode write if accepted, otherwise a bubble.
    always_comb begin
        e0_d = '0;
        if (ins_i) begin
            e0_d.valid = 1'b1;
            e0_d.wr    = SB_AW'(ins_wr_i);
            e0_d.load  = ins_load_i;
        end
    end

    // Shift EX into the accumulator slot every cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            e0_q <= '0;
            e1_q <= '0;
        end else begin
            e0_q <= e0_d;
            e1_q <= e0_q;
        end
    end

    // Both sources matched in parallel; EX holds the youngest write and wins.
    always_comb begin
        rs_m0 = src_match(e0_q, rs_used_i, SB_AW'(rs_i));
        rs_m1 = src_match(e1_q, rs_used_i, SB_AW'(rs_i));
        rt_m0 = src_match(e0_q, rt_used_i, SB_AW'(rt_i));
        rt_m1 = src_match(e1_q, rt_used_i, SB_AW'(rt_i));

        fwd_rs_c_o = FWD_RF;
        if (rs_m0)      fwd_rs_c_o = FWD_EX;
        else if (rs_m1) fwd_rs_c_o = FWD_ACC;

        fwd_rt_c_o = FWD_RF;
        if (rt_m0)      fwd_rt_c_o = FWD_EX;
        else if (rt_m1) fwd_rt_c_o = FWD_ACC;

        load_hit_c_o = e0_q.load & (rs_m0 | rt_m0);
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard/flush controller: load-use stall, multi-cycle branch flush, saturating event counters.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int unsigned REG_AW       = 4,
    parameter int unsigned FLUSH_CYCLES = 2,
    parameter int unsigned CNT_W        = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic              id_rs_used,
    input  logic              id_rt_used,
    input  logic              id_write,
    input  logic [REG_AW-1:0] id_wr,
    input  logic              id_load,
    input  logic              br_taken,
    output logic              stall,
    output logic              flush,
    output logic [1:0]        fwd_rs,
    output logic [1:0]        fwd_rt,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    logic [0:0]        state_q, state_d;
    logic [FCNT_W-1:0] fcnt_q, fcnt_d;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;
    logic              flush_c, stall_c, trig_c, ins_c, load_hit_c;
    logic [1:0]        fwd_rs_c, fwd_rt_c;

    hazard_scoreboard #(
        .REG_AW (REG_AW)
    ) u_sb (
        .clk          (clk),
        .rst_n        (rst),
        .ins_i        (ins_c),
        .ins_wr_i     (id_wr),
        .ins_load_i   (id_load),
        .rs_i         (id_rs),
        .rs_used_i    (id_rs_used),
        .rt_i         (id_rt),
        .rt_used_i    (id_rt_used),
        .fwd_rs_c_o   (fwd_rs_c),
        .fwd_rt_c_o   (fwd_rt_c),
        .load_hit_c_o (load_hit_c)
    );

    // Same-cycle control; everything gated low while reset is held.
    always_comb begin
        flush_c = rst & (br_taken | (state_q == ST_FLUSH));
        stall_c = rst & id_valid & ~flush_c & load_hit_c;
        trig_c  = rst & br_taken & (state_q == ST_RUN);
        ins_c   = id_valid & id_write & (id_wr != '0) & ~stall_c & ~flush_c;
    end

    assign flush     = flush_c;
    assign stall     = stall_c;
    assign fwd_rs    = rst ? fwd_rs_c : FWD_RF;
    assign fwd_rt    = rst ? fwd_rt_c : FWD_RF;
    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;

    // Flush sequencing: first cycle is combinational, remaining cycles come from FLUSH.
    always_comb begin
        state_d = state_q;
        fcnt_d  = fcnt_q;
        case (state_q)
            ST_RUN: begin
                if (br_taken && (FLUSH_CYCLES > 1)) begin
                    state_d = ST_FLUSH;
                    fcnt_d  = FCNT_W'(FLUSH_CYCLES - 2);
                end
            end
            ST_FLUSH: begin
                if (fcnt_q == '0) state_d = ST_RUN;
                else              fcnt_d  = fcnt_q - FCNT_W'(1);
            end
            default: state_d = ST_RUN;
        endcase
    end

    // Saturating debug counters.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (stall_c && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + CNT_W'(1);
        if (trig_c  && (flush_cnt_q != '1)) flush_cnt_d = flush_cnt_q + CNT_W'(1);
    end

    // State registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_RUN;
            fcnt_q      <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            fcnt_q      <= fcnt_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed hazard scenarios plus random traffic vs a reference model.
module tb_hazard_ctrl;

    localparam int FC    = 2;
    localparam int CW    = 4;
    localparam int MAXC  = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          id_valid = 1'b0;
    logic [3:0]    id_rs = '0, id_rt = '0, id_wr = '0;
    logic          id_rs_used = 1'b0, id_rt_used = 1'b0, id_write = 1'b0, id_load = 1'b0;
    logic          br_taken = 1'b0;
    logic          stall, flush;
    logic [1:0]    fwd_rs, fwd_rt;
    logic [CW-1:0] stall_cnt, flush_cnt;

    int n_pass = 0;
    int n_tot  = 0;

    hazard_ctrl #(.REG_AW(4), .FLUSH_CYCLES(FC), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_rs_used(id_rs_used), .id_rt_used(id_rt_used), .id_write(id_write),
        .id_wr(id_wr), .id_load(id_load), .br_taken(br_taken), .stall(stall),
        .flush(flush), .fwd_rs(fwd_rs), .fwd_rt(fwd_rt), .stall_cnt(stall_cnt),
        .flush_cnt(flush_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit      stall;
        bit      flush;
        bit [1:0] fr;
        bit [1:0] ft;
        int      sc;
        int      fc;
    } exp_t;

    // One in-flight write as seen by the model: which register, and whether it is a load.
    typedef struct {
        bit v;
        int wr;
        bit ld;
    } wr_t;

    exp_t eq[$];
    wr_t  in_ex, in_acc;
    int   flush_left, m_sc, m_fc;

    task automatic chk(input string name, input int act, input int exp);
        n_tot++;
        if (act !== exp) $display("FAIL %s actual=%0d required=%0d t=%0t", name, act, exp, $time);
        else n_pass++;
    endtask

    function automatic bit hit(input wr_t s, input bit used, input int a);
        return used && (a != 0) && s.v && (s.wr == a);
    endfunction

    function automatic bit [1:0] fwd_of(input bit used, input int a);
        if (hit(in_ex, used, a))  return 2'd1;
        if (hit(in_acc, used, a)) return 2'd2;
        return 2'd0;
    endfunction

    task automatic model_reset();
        in_ex = '{v: 1'b0, wr: 0, ld: 1'b0};
        in_acc = in_ex;
        flush_left = 0;
        m_sc = 0;
        m_fc = 0;
    endtask

    // Apply one cycle of ID/EX inputs and queue the expected same-cycle response.
    task automatic drive(input bit v, input int rs, input bit rsu, input int rt, input bit rtu,
                         input bit w, input int wr, input bit ld, input bit br);
        exp_t e;
        bit   fl, st;
        @(negedge clk);
        id_valid = v; id_rs = 4'(rs); id_rs_used = rsu; id_rt = 4'(rt); id_rt_used = rtu;
        id_write = w; id_wr = 4'(wr); id_load = ld; br_taken = br;
        #1;
        fl = br || (flush_left > 0);
        st = v && !fl && in_ex.ld && (hit(in_ex, rsu, rs) || hit(in_ex, rtu, rt));
        e.stall = st; e.flush = fl;
        e.fr = fwd_of(rsu, rs); e.ft = fwd_of(rtu, rt);
        e.sc = m_sc; e.fc = m_fc;
        eq.push_back(e);
        if (st && m_sc < MAXC) m_sc++;
        if (flush_left > 0) flush_left--;
        else if (br) begin
            flush_left = FC - 1;
            if (m_fc < MAXC) m_fc++;
        end
        in_acc = in_ex;
        if (v && w && wr != 0 && !st && !fl) in_ex = '{v: 1'b1, wr: wr, ld: ld};
        else                                 in_ex = '{v: 1'b0, wr: 0, ld: 1'b0};
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // Monitor: compare every presented cycle against the oldest queued expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (eq.size() > 0) begin
                e = eq.pop_front();
                chk("stall", int'(stall), int'(e.stall));
                chk("flush", int'(flush), int'(e.flush));
                chk("fwd_rs", int'(fwd_rs), int'(e.fr));
                chk("fwd_rt", int'(fwd_rt), int'(e.ft));
                chk("stall_cnt", int'(stall_cnt), e.sc);
                chk("flush_cnt", int'(flush_cnt), e.fc);
            end
        end
    end

    initial begin
        model_reset();
        repeat (3) @(negedge clk);
        chk("rst_stall", int'(stall), 0);
        chk("rst_flush", int'(flush), 0);
        chk("rst_stall_cnt", int'(stall_cnt), 0);
        chk("rst_flush_cnt", int'(flush_cnt), 0);
        rst = 1'b1;

        // ALU dependence: write r3, read r3 next cycle (EX), then the cycle after (ACC)
        drive(1, 0, 0, 0, 0, 1, 3, 0, 0);
        drive(1, 3, 1, 0, 0, 0, 0, 0, 0);
        drive(1, 0, 0, 3, 1, 0, 0, 0, 0);
        #1 chk("alu_rt_acc", int'(fwd_rt), 2);

        // Load-use: load r5, read r5 (stall), re-read r5 (forward from ACC)
        drive(1, 0, 0, 0, 0, 1, 5, 1, 0);
        drive(1, 5, 1, 0, 0, 0, 0, 0, 0);
        drive(1, 5, 1, 0, 0, 0, 0, 0, 0);
        #1 chk("lu_cnt", int'(stall_cnt), 1);

        // Branch with retrigger attempt in the second flush cycle
        drive(1, 0, 0, 0, 0, 0, 0, 0, 1);
        drive(1, 0, 0, 0, 0, 0, 0, 0, 1);
        idle();
        #1 chk("br_cnt", int'(flush_cnt), 1);

        // Branch together with load-use: no stall, no insertion
        drive(1, 0, 0, 0, 0, 1, 6, 1, 0);
        drive(1, 6, 1, 0, 0, 1, 9, 1, 1);
        idle();
        drive(1, 9, 1, 6, 1, 0, 0, 0, 0);

        // Register 0 never hazards; youngest of two writes to r7 wins
        drive(1, 0, 0, 0, 0, 1, 0, 1, 0);
        drive(1, 0, 1, 0, 1, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0, 1, 7, 0, 0);
        drive(1, 0, 0, 0, 0, 1, 7, 0, 0);
        drive(1, 7, 1, 7, 1, 0, 0, 0, 0);

        // Async reset during the first flush cycle
        drive(1, 0, 0, 0, 0, 0, 0, 0, 1);
        #2;
        rst = 1'b0;
        id_valid = 1'b1; id_rs = 4'd7; id_rs_used = 1'b1;
        #1;
        chk("ar_flush", int'(flush), 0);
        chk("ar_stall", int'(stall), 0);
        chk("ar_fwd_rs", int'(fwd_rs), 0);
        chk("ar_stall_cnt", int'(stall_cnt), 0);
        chk("ar_flush_cnt", int'(flush_cnt), 0);
        model_reset();
        @(negedge clk);
        chk("ar_hold_flush", int'(flush), 0);
        br_taken = 1'b0; id_valid = 1'b0; id_rs_used = 1'b0;
        rst = 1'b1;
        drive(1, 0, 0, 0, 0, 0, 0, 0, 1);
        idle();
        idle();
        idle();

        // Counter saturation: many load-use stalls and branches
        for (int i = 0; i < 20; i++) begin
            drive(1, 0, 0, 0, 0, 1, 1, 1, 0);
            drive(1, 0, 0, 1, 1, 0, 0, 0, 0);
            drive(1, 0, 0, 0, 0, 0, 0, 0, 1);
            idle();
        end
        #1 chk("sat_stall", int'(stall_cnt), MAXC);
        chk("sat_flush", int'(flush_cnt), MAXC);

        // Random traffic against the model
        for (int i = 0; i < 600; i++) begin
            drive($urandom_range(0, 3) != 0, int'($urandom_range(0, 7)), $urandom_range(0, 3) != 0,
                  int'($urandom_range(0, 7)), $urandom_range(0, 1) != 0, $urandom_range(0, 3) != 0,
                  int'($urandom_range(0, 7)), $urandom_range(0, 2) == 0, $urandom_range(0, 9) == 0);
        end

        @(negedge clk);
        #3;
        chk("queue_drained", eq.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard and flush controller for the 16-bit MIPS-style core. It tracks in-flight register writes in a two-entry scoreboard that mirrors the EX stage and the accumulator buffer stage. From that scoreboard it drives operand-forwarding selects and load-use stalls. It also sequences the multi-cycle flush that clears the pipeline registers after a taken branch, and keeps saturating stall/flush event counters for debug.

## Interface
Parameters:
- REG_AW, 4: register address width (16-entry register file; register 0 is hardwired zero).
- FLUSH_CYCLES, 2: number of consecutive cycles `flush` is asserted per taken branch (legal range 1 to 7).
- CNT_W, 16: width of the event counters.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-low reset.
- id_valid  in  1  decode stage holds a valid instruction.
- id_rs, id_rt  in  REG_AW  decode source register addresses.
- id_rs_used, id_rt_used  in  1  the corresponding source is actually read.
- id_write  in  1  decode instruction writes a register.
- id_wr  in  REG_AW  decode destination register.
- id_load  in  1  decode instruction is a memory load (result is valid only at the accumulator stage).
- br_taken  in  1  branch resolved taken in EX this cycle.
- stall  out  1  freeze PC and IF/ID; insert a bubble into EX.
- flush  out  1  drives the `branch` input of the pipeline registers.
- fwd_rs, fwd_rt  out  2  forwarding select: 0 = register file, 1 = EX result, 2 = accumulator output; 3 is never driven.
- stall_cnt, flush_cnt  out  CNT_W  saturating event counters.

## Operation
- **Scoreboard entries.** The scoreboard has two entries of {valid, wr, load}.
  - E0 is the instruction now in EX.
  - E1 is the instruction now in the accumulator stage.
- **Scoreboard update, every cycle.**
  - E1 is loaded from E0.
  - E0 is loaded with the decode instruction when `id_valid & id_write & (id_wr != 0) & ~stall & ~flush`. Otherwise E0 receives a bubble (valid = 0).
- **Source match.** A source matches an entry when all of the following hold:
  - the source's `_used` signal is 1;
  - the source address is nonzero;
  - the entry is valid;
  - the entry's wr equals the source address.
- **Forwarding.**
  - A match on E0 gives fwd = 1.
  - Otherwise a match on E1 gives fwd = 2.
  - Otherwise fwd = 0.
  - E0 has priority because it holds the youngest write.
- **Load-use stall.** `stall` = `id_valid & ~flush & (either used source matches E0 with E0.load = 1)`.
  - While stalled, E0 receives a bubble.
  - On the next cycle the load is in E1 and fwd = 2.
- **Flush state machine.** States are RUN and FLUSH, with a 3-bit down counter.
  - `flush` = `br_taken | (state == FLUSH)`. The first flush cycle is combinational in the same cycle as `br_taken`.
  - In RUN, `br_taken` with FLUSH_CYCLES > 1 moves the FSM to FLUSH and loads the counter with FLUSH_CYCLES-2. With FLUSH_CYCLES = 1 the FSM stays in RUN.
  - In FLUSH, the FSM returns to RUN when the counter is 0; otherwise the counter decrements.
  - `br_taken` is ignored while in FLUSH: no retrigger and no extension.
- **Flush versus stall.** Flush wins over stall: `stall` is 0 whenever `flush` is 1. E0 is not killed by flush, because the branch itself is in E0.
- **Event counters.**
  - `stall_cnt` increments on each cycle with `stall` = 1.
  - `flush_cnt` increments on each RUN→flush trigger, meaning once per accepted branch.
  - Both saturate at all-ones.

## Timing
- **Reset (rst = 0), asynchronous.**
  - Both entries become invalid.
  - The FSM goes to RUN and the counter to 0.
  - Both event counters go to 0.
  - `stall`, `flush` and both fwd outputs are forced to 0 while reset is asserted, regardless of inputs.
  - Release of rst is synchronous to clk.
- **Combinational paths.**
  - `stall`, `flush` and both fwd outputs are combinational from the current state plus the same-cycle ID inputs and `br_taken`. They have zero latency.
  - Scoreboard, FSM and counters update on the rising edge.
- **Simultaneous events.**
  - `br_taken` together with a load-use condition: flush = 1, stall = 0, and E0 receives a bubble.
  - `br_taken` arriving in the last FLUSH cycle is ignored.
- **Reset mid-flush.** The FSM goes to RUN immediately and flush drops asynchronously.
- **Register 0.** It never creates a hazard, a forward or a scoreboard entry.

## Structure
- **Package `hazard_pkg`, contents:**
  - fwd encodings FWD_RF = 0, FWD_EX = 1, FWD_ACC = 2;
  - FSM state encoding (RUN, FLUSH);
  - the scoreboard entry struct {valid, wr, load}.
- **Sub-module `hazard_scoreboard`:**
  - holds the two-entry shift register and the match/forwarding logic;
  - instantiated once, with the two sources evaluated in parallel.
- **Top level, `hazard_ctrl`:**
  - holds the flush FSM, the stall gating and the event counters.

## Test plan
- **Back-to-back ALU dependence.** Issue write r3, then the next cycle read rs = r3. Required: fwd_rs = 1, stall = 0. One cycle later with rt = r3: fwd_rt = 2.
- **Load-use.** Issue a load to r5, then immediately read r5. Required: stall = 1 for exactly 1 cycle, then fwd = 2, and stall_cnt = 1.
- **Branch flush with FLUSH_CYCLES = 2.** Pulse br_taken for one cycle. Required: flush = 1 for 2 cycles and flush_cnt = 1. A second br_taken during the second flush cycle is ignored: flush is still 2 cycles total and flush_cnt is still 1.
- **Branch plus load-use in the same cycle.** Required: flush = 1, stall = 0, and no scoreboard entry is inserted, so a read of that load's destination two cycles later gives fwd = 0.
- **Register 0 and priority.** A write to r0 followed by a read of r0 gives fwd = 0 and no stall. Two writes to r7 on consecutive cycles followed by a read of r7 give fwd = 1, because the youngest write wins.
- **Async reset mid-flush.** Drive rst low during the first flush cycle. Required: flush = 0 immediately, both counters read 0, and after release a new br_taken again yields a full 2-cycle flush.
